rom_flash_loader: RTL



---
 rtl/rom_flash_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rom_flash_loader.sv
// rom_flash_loader
// Copies a boot image from SPI flash (standard READ, opcode 0x03) into the
// writable boot-ROM BRAM after a one-cycle start request. While a load is in
// progress the loader owns the BRAM address/write port, and CPU ROM reads are
// stalled through cpu_wait_n.
//
// SPI is mode 0 with SCK = clk/2. Each bit takes two clocks: phase L
// (flash_clk low, mosi valid), then phase H (flash_clk high). miso is sampled
// on the clk edge that ends phase H.
//
// Optional build macro: ROM_LOADER_CHECKSUM_EN
//   defined   : checksum is a 16-bit wrapping sum of every byte written
//   undefined : checksum is tied to zero and no accumulator exists
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle load request (honoured in IDLE or DONE only)
//   cpu_a, cpu_rd     CPU ROM address / read active
//   cpu_wait_n        low stalls the CPU (read during a load)
//   rom_a             BRAM address: load index while busy, else cpu_a
//   rom_din, rom_we   BRAM write data / one-clock write strobe
//   busy, done        load in progress / image loaded (sticky)
//   checksum          image byte sum (see macro above)
//   flash_cs_n, flash_clk, flash_mosi, flash_miso   SPI flash pins
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, CPU owns the ROM port
// CSSETUP | cs_n low for one clk, command MSB already on mosi
// CMD     | shifting 0x03 + 24-bit flash address, 64 clks
// DATA    | receiving bytes, one BRAM write per byte
// CSHOLD  | cs_n high for one clk before handing back the port
// DONE    | image loaded, done high until the next start or reset

module rom_flash_loader #(
    parameter logic [23:0] FLASH_ADDR = 24'h0C0000,
    parameter int          ROM_BYTES  = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] cpu_a,
    input  logic        cpu_rd,
    output logic        cpu_wait_n,
    output logic [13:0] rom_a,
    output logic [7:0]  rom_din,
    output logic        rom_we,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum,
    output logic        flash_cs_n,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CSSETUP = 3'd1;
    localparam logic [2:0] CMD     = 3'd2;
    localparam logic [2:0] DATA    = 3'd3;
    localparam logic [2:0] CSHOLD  = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [31:0] CMD_WORD = {8'h03, FLASH_ADDR};
    localparam logic [13:0] LAST_IDX = 14'(ROM_BYTES - 1);

    logic [2:0]  state;
    logic [13:0] idx;
    logic [31:0] cmd_sr;     // remaining command bits, next bit at [31]
    logic [4:0]  bit_cnt;    // down-counter, terminal count at 0
    logic [6:0]  rx_sr;
    logic        last_wr;    // final byte is being written this clk
    logic        load_req;

    assign load_req   = start && ((state == IDLE) || (state == DONE));
    assign cpu_wait_n = ~(busy & cpu_rd);
    assign rom_a      = busy ? idx : cpu_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            flash_cs_n <= 1'b1;
            flash_clk  <= 1'b0;
            flash_mosi <= 1'b0;
            rom_we     <= 1'b0;
            rom_din    <= 8'h00;
            idx        <= 14'd0;
            cmd_sr     <= 32'd0;
            bit_cnt    <= 5'd0;
            rx_sr      <= 7'd0;
            last_wr    <= 1'b0;
        end else begin
            rom_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (load_req) begin
                        state      <= CSSETUP;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        idx        <= 14'd0;
                        flash_cs_n <= 1'b0;
                        flash_clk  <= 1'b0;
                        flash_mosi <= CMD_WORD[31];
                        cmd_sr     <= {CMD_WORD[30:0], 1'b0};
                        bit_cnt    <= 5'd31;
                        last_wr    <= 1'b0;
                    end
                end
                CSSETUP: begin
                    // mosi already holds the MSB; this clk is bit 31 setup
                    state <= CMD;
                end
                CMD: begin
                    if (!flash_clk) begin
                        flash_clk <= 1'b1;
                    end else begin
                        flash_clk <= 1'b0;
                        if (bit_cnt == 5'd0) begin
                            state      <= DATA;
                            bit_cnt    <= 5'd7;
                            flash_mosi <= 1'b0;
                        end else begin
                            bit_cnt    <= bit_cnt - 5'd1;
                            flash_mosi <= cmd_sr[31];
                            cmd_sr     <= {cmd_sr[30:0], 1'b0};
                        end
                    end
                end
                DATA: begin
                    // index advances once the write strobe for it has been
                    // issued; the final index is held so 16383 never wraps
                    if (rom_we && !last_wr)
                        idx <= idx + 14'd1;
                    if (last_wr) begin
                        state      <= CSHOLD;
                        flash_cs_n <= 1'b1;
                    end else if (!flash_clk) begin
                        flash_clk <= 1'b1;
                    end else begin
                        // next byte starts shifting in the write clk, so
                        // SCK never pauses between bytes
                        flash_clk <= 1'b0;
                        rx_sr     <= {rx_sr[5:0], flash_miso};
                        if (bit_cnt == 5'd0) begin
                            rom_we  <= 1'b1;
                            rom_din <= {rx_sr, flash_miso};
                            bit_cnt <= 5'd7;
                            if (idx == LAST_IDX)
                                last_wr <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                CSHOLD: begin
                    state   <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    last_wr <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum <= 16'h0000;
        else if (load_req)
            sum <= 16'h0000;
        else if (rom_we)
            sum <= sum + {8'h00, rom_din};
    end

    assign checksum = sum;
`else
    assign checksum = 16'h0000;
`endif

endmodule
